// File: rtl/ponylink_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : ponylink_traffic_gen
// Purpose  : Self-checking traffic driver for a ponylink_master in loopback
//            benches. Sequences the master reset, waits for linkready, streams
//            a deterministic word sequence into the master and checks the
//            echoed stream against the same sequence.
// Revision : 1.0 - initial release
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   link_resetn         drives ponylink_master resetn
//   linkready           from ponylink_master linkready
//   tx_t*               AXI-stream style output to master in_t*
//   rx_t*               AXI-stream style input from master out_t*
//   done                run finished (pass or fail), sticky
//   error               any mismatch or timeout, sticky
//   timeout             run ended by the progress timer, sticky
//   err_count           mismatching received words, saturating at 255
//
// Word i: tdata = SEED + i, tuser = ~i, tlast at packet end or final word.
//
// Build option:
//   PONYLINK_TGEN_BACKPRESSURE_EN - when defined, a 16-bit LFSR throttles
//   rx_tready during RUN (about 75% duty) to exercise master backpressure.
// ============================================================================
module ponylink_traffic_gen #(
  parameter int unsigned TDATA_WIDTH  = 8,
  parameter int unsigned TUSER_WIDTH  = 4,
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned PKT_LEN      = 4,
  parameter int unsigned SEED         = 'h17,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   link_resetn,
  input  logic                   linkready,
  output logic [TDATA_WIDTH-1:0] tx_tdata,
  output logic [TUSER_WIDTH-1:0] tx_tuser,
  output logic                   tx_tvalid,
  output logic                   tx_tlast,
  input  logic                   tx_tready,
  input  logic [TDATA_WIDTH-1:0] rx_tdata,
  input  logic [TUSER_WIDTH-1:0] rx_tuser,
  input  logic                   rx_tvalid,
  input  logic                   rx_tlast,
  output logic                   rx_tready,
  output logic                   done,
  output logic                   error,
  output logic                   timeout,
  output logic [7:0]             err_count
);

  localparam int unsigned IW = $clog2(NUM_WORDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

  localparam logic [IW-1:0] NW_IDX   = IW'(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_HOLD  = 2'd0,
    WAIT_LINK = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, next_state;

  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] timer;
  logic [IW-1:0] tx_idx;
  logic [IW-1:0] rx_idx;
  logic [IW-1:0] tx_next;
  logic          rx_fire;
  logic          tx_fire;
  logic          rx_mismatch;
  logic          bp_ok;

  // Sequence generator shared by the transmitter and the receive checker.
  function automatic logic [TDATA_WIDTH-1:0] word_tdata(input logic [IW-1:0] i);
    word_tdata = TDATA_WIDTH'(SEED + 32'(i));
  endfunction

  function automatic logic [TUSER_WIDTH-1:0] word_tuser(input logic [IW-1:0] i);
    word_tuser = TUSER_WIDTH'(~(32'(i)));
  endfunction

  function automatic logic word_tlast(input logic [IW-1:0] i);
    word_tlast = ((32'(i) % PKT_LEN) == (PKT_LEN - 1)) || (32'(i) == (NUM_WORDS - 1));
  endfunction

`ifdef PONYLINK_TGEN_BACKPRESSURE_EN
  // Fibonacci LFSR, taps 16,14,13,11; free-running outside reset.
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
  assign bp_ok = lfsr[0] | lfsr[1];
`else
  assign bp_ok = 1'b1;
`endif

  assign rx_tready   = (state == RUN) && bp_ok;
  assign rx_fire     = rx_tvalid && rx_tready;
  assign tx_fire     = tx_tvalid && tx_tready;
  assign tx_next     = tx_idx + IW'(1);
  assign done        = (state == DONE);
  assign rx_mismatch = (rx_tdata != word_tdata(rx_idx)) ||
                       (rx_tuser != word_tuser(rx_idx)) ||
                       (rx_tlast != word_tlast(rx_idx));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_HOLD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Leaving RUN on the final acceptance (rather than one
  // cycle later) guarantees no word is ever accepted with rx_idx==NUM_WORDS.
  always_comb begin
    next_state = state;
    case (state)
      RST_HOLD: begin
        if (rst_cnt == RST_LAST) next_state = WAIT_LINK;
      end
      WAIT_LINK: begin
        if (linkready)               next_state = RUN;
        else if (timer == TO_LAST)   next_state = DONE;
      end
      RUN: begin
        if (rx_fire && (rx_idx == LAST_IDX))  next_state = DONE;
        else if (!rx_fire && (timer == TO_LAST)) next_state = DONE;
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = RST_HOLD;
      end
    endcase
  end

  // Datapath, counters and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_resetn <= 1'b0;
      rst_cnt     <= '0;
      timer       <= '0;
      tx_idx      <= '0;
      rx_idx      <= '0;
      tx_tvalid   <= 1'b0;
      tx_tdata    <= '0;
      tx_tuser    <= '0;
      tx_tlast    <= 1'b0;
      error       <= 1'b0;
      timeout     <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        RST_HOLD: begin
          rst_cnt <= rst_cnt + RW'(1);
          if (rst_cnt == RST_LAST) link_resetn <= 1'b1;
        end

        WAIT_LINK: begin
          if (linkready) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timeout <= 1'b1;
            error   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RUN: begin
          // Progress timer: only accepted words count as progress.
          if (rx_fire) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timeout <= 1'b1;
            error   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end

          // Transmitter: next word is loaded on the transfer edge so
          // back-to-back transfers need no bubble.
          if (next_state == DONE) begin
            tx_tvalid <= 1'b0;
          end else if (tx_fire) begin
            tx_idx <= tx_next;
            if (tx_next < NW_IDX) begin
              tx_tvalid <= 1'b1;
              tx_tdata  <= word_tdata(tx_next);
              tx_tuser  <= word_tuser(tx_next);
              tx_tlast  <= word_tlast(tx_next);
            end else begin
              tx_tvalid <= 1'b0;
            end
          end else if (!tx_tvalid && (tx_idx < NW_IDX)) begin
            tx_tvalid <= 1'b1;
            tx_tdata  <= word_tdata(tx_idx);
            tx_tuser  <= word_tuser(tx_idx);
            tx_tlast  <= word_tlast(tx_idx);
          end

          // Receiver check
          if (rx_fire) begin
            rx_idx <= rx_idx + IW'(1);
            if (rx_mismatch) begin
              error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end

        DONE: begin
          tx_tvalid <= 1'b0;
        end

        default: begin
          tx_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ponylink_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ponylink_traffic_gen
// Purpose  : Loopback bench for ponylink_traffic_gen. An echo model returns
//            each transmitted word 10 cycles later, optionally corrupting or
//            dropping one word; expected tx words are queued up front and
//            popped as the generator emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ponylink_traffic_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       linkready = 1'b0;
  logic       tx_tready = 1'b0;
  logic [7:0] rx_tdata = 8'h00;
  logic [3:0] rx_tuser = 4'h0;
  logic       rx_tvalid = 1'b0;
  logic       rx_tlast = 1'b0;

  logic       link_resetn;
  logic [7:0] tx_tdata;
  logic [3:0] tx_tuser;
  logic       tx_tvalid;
  logic       tx_tlast;
  logic       rx_tready;
  logic       done;
  logic       error;
  logic       timeout;
  logic [7:0] err_count;

  ponylink_traffic_gen dut (
    .clk         (clk),
    .reset       (reset),
    .link_resetn (link_resetn),
    .linkready   (linkready),
    .tx_tdata    (tx_tdata),
    .tx_tuser    (tx_tuser),
    .tx_tvalid   (tx_tvalid),
    .tx_tlast    (tx_tlast),
    .tx_tready   (tx_tready),
    .rx_tdata    (rx_tdata),
    .rx_tuser    (rx_tuser),
    .rx_tvalid   (rx_tvalid),
    .rx_tlast    (rx_tlast),
    .rx_tready   (rx_tready),
    .done        (done),
    .error       (error),
    .timeout     (timeout),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] u;
    logic       l;
    int         due;
  } ent_t;

  ent_t exp_q[$];
  ent_t dq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int tx_n;
  int tlast_n;
  bit seen_tx;
  bit saw_rx_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_link_resetn"}, 32'(link_resetn), 32'd0);
    check({tag, "_tx_tvalid"},   32'(tx_tvalid),   32'd0);
    check({tag, "_tx_tdata"},    32'(tx_tdata),    32'd0);
    check({tag, "_tx_tuser"},    32'(tx_tuser),    32'd0);
    check({tag, "_tx_tlast"},    32'(tx_tlast),    32'd0);
    check({tag, "_rx_tready"},   32'(rx_tready),   32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_error"},       32'(error),       32'd0);
    check({tag, "_timeout"},     32'(timeout),     32'd0);
    check({tag, "_err_count"},   32'(err_count),   32'd0);
  endtask

  // Reset, check reset values, release and check link_resetn timing.
  task automatic do_reset();
    reset     = 1'b1;
    tx_tready = 1'b0;
    rx_tvalid = 1'b0;
    rx_tdata  = 8'h00;
    rx_tuser  = 4'h0;
    rx_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("link_lo_edge3", 32'(link_resetn), 32'd0);
    @(posedge clk);
    #1;
    check("link_hi_edge4", 32'(link_resetn), 32'd1);
  endtask

  // One traffic run with the echo model. corrupt/drop select a word index
  // (-1 = none); abort_at>0 asserts reset after that many tx transfers.
  task automatic run(input int corrupt, input int drop, input bit toggle,
                     input int abort_at, input int budget);
    int         cyc;
    bit         stalled;
    logic [7:0] hd;
    logic [3:0] hu;
    logic       hl;
    ent_t       e;
    exp_q.delete();
    dq.delete();
    tx_n       = 0;
    tlast_n    = 0;
    seen_tx    = 1'b0;
    saw_rx_low = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e.d   = 8'(8'h17 + i);
      e.u   = 4'(15 - i);
      e.l   = ((i % 4) == 3) || (i == 15);
      e.due = 0;
      exp_q.push_back(e);
    end
    cyc     = 0;
    stalled = 1'b0;
    hd = 8'h00; hu = 4'h0; hl = 1'b0;
    while ((done !== 1'b1) && (cyc < budget)) begin
      if (stalled) begin
        check("stall_valid", 32'(tx_tvalid), 32'd1);
        check("stall_tdata", 32'(tx_tdata),  32'(hd));
        check("stall_tuser", 32'(tx_tuser),  32'(hu));
        check("stall_tlast", 32'(tx_tlast),  32'(hl));
      end
      tx_tready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if ((dq.size() > 0) && (dq[0].due <= cyc)) begin
        rx_tvalid = 1'b1;
        rx_tdata  = dq[0].d;
        rx_tuser  = dq[0].u;
        rx_tlast  = dq[0].l;
      end else begin
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        rx_tuser  = 4'h0;
        rx_tlast  = 1'b0;
      end
      if (tx_tvalid) seen_tx = 1'b1;
      if (seen_tx && !rx_tready) saw_rx_low = 1'b1;
      stalled = tx_tvalid && !tx_tready;
      hd = tx_tdata; hu = tx_tuser; hl = tx_tlast;
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_overrun", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("tx_tdata", 32'(tx_tdata), 32'(e.d));
          check("tx_tuser", 32'(tx_tuser), 32'(e.u));
          check("tx_tlast", 32'(tx_tlast), 32'(e.l));
        end
        if (tx_tlast) tlast_n++;
        if (tx_n != drop) begin
          e.d   = tx_tdata ^ ((tx_n == corrupt) ? 8'h01 : 8'h00);
          e.u   = tx_tuser;
          e.l   = tx_tlast;
          e.due = cyc + 10;
          dq.push_back(e);
        end
        tx_n++;
      end
      if (rx_tvalid && rx_tready) void'(dq.pop_front());
      @(posedge clk);
      #1;
      cyc++;
      if ((abort_at > 0) && (tx_n == abort_at)) begin
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        break;
      end
    end
    rx_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: ideal loopback
    linkready = 1'b1;
    do_reset();
    run(-1, -1, 1'b0, 0, 3000);
    check("s1_done",      32'(done),      32'd1);
    check("s1_error",     32'(error),     32'd0);
    check("s1_timeout",   32'(timeout),   32'd0);
    check("s1_err_count", 32'(err_count), 32'd0);
    check("s1_tx_words",  32'(tx_n),      32'd16);
    check("s1_tlast_cnt", 32'(tlast_n),   32'd4);
    check("s1_tx_tvalid", 32'(tx_tvalid), 32'd0);
    check("s1_rx_tready", 32'(rx_tready), 32'd0);
`ifdef PONYLINK_TGEN_BACKPRESSURE_EN
    check("s1_rx_backpressure_seen", 32'(saw_rx_low), 32'd1);
`else
    check("s1_rx_always_ready", 32'(saw_rx_low), 32'd0);
`endif

    // 2: tdata of word 5 corrupted
    do_reset();
    run(5, -1, 1'b0, 0, 3000);
    check("s2_done",      32'(done),      32'd1);
    check("s2_error",     32'(error),     32'd1);
    check("s2_timeout",   32'(timeout),   32'd0);
    check("s2_err_count", 32'(err_count), 32'd1);

    // 3: link never comes up
    linkready = 1'b0;
    do_reset();
    run(-1, -1, 1'b0, 0, 1500);
    check("s3_done",     32'(done),    32'd1);
    check("s3_error",    32'(error),   32'd1);
    check("s3_timeout",  32'(timeout), 32'd1);
    check("s3_no_tx",    32'(seen_tx), 32'd0);

    // 4: word 9 dropped by the echo model
    linkready = 1'b1;
    do_reset();
    run(-1, 9, 1'b0, 0, 2500);
    check("s4_done",       32'(done),             32'd1);
    check("s4_error",      32'(error),            32'd1);
    check("s4_timeout",    32'(timeout),          32'd1);
    check("s4_err_ge6",    32'(err_count >= 8'd6), 32'd1);

    // 5: tx backpressure, reset mid-run at word 7, then a clean rerun
    do_reset();
    run(-1, -1, 1'b1, 7, 3000);
    do_reset();
    run(-1, -1, 1'b1, 0, 3000);
    check("s5_done",      32'(done),      32'd1);
    check("s5_error",     32'(error),     32'd0);
    check("s5_timeout",   32'(timeout),   32'd0);
    check("s5_err_count", 32'(err_count), 32'd0);
    check("s5_tx_words",  32'(tx_n),      32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ponylink_traffic_gen.md
Name: ponylink_traffic_gen

Overview:
Self-checking traffic driver for a ponylink_master instance in loopback test benches.
- Sequences master resetn and waits for linkready.
- Streams a deterministic word sequence into the master's in_t* port.
- Consumes the echoed stream from the master's out_t* port, compares it against the same sequence, and reports done/error.
- Replaces the ad-hoc reset/stimulus FSM in loopback harnesses and scales to multi-word, multi-packet traffic.

Parameters:
- TDATA_WIDTH, 8, width of tdata on both streams.
- TUSER_WIDTH, 4, width of tuser on both streams.
- NUM_WORDS, 16, words sent and expected back (>=1).
- PKT_LEN, 4, words per packet; tlast marks packet end (>=1).
- SEED, 8'h17, tdata base value.
- RESET_CYCLES, 4, cycles link_resetn is held low after reset release (>=1).
- TIMEOUT, 1024, cycles allowed without link or receive progress before timeout error.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- link_resetn, output, 1, drives ponylink_master resetn.
- linkready, input, 1, from ponylink_master linkready.
- tx_tdata, output, TDATA_WIDTH, to master in_tdata.
- tx_tuser, output, TUSER_WIDTH, to master in_tuser.
- tx_tvalid, output, 1, to master in_tvalid.
- tx_tlast, output, 1, to master in_tlast.
- tx_tready, input, 1, from master in_tready.
- rx_tdata, input, TDATA_WIDTH, from master out_tdata.
- rx_tuser, input, TUSER_WIDTH, from master out_tuser.
- rx_tvalid, input, 1, from master out_tvalid.
- rx_tlast, input, 1, from master out_tlast.
- rx_tready, output, 1, to master out_tready.
- done, output, 1, run complete (pass or fail); sticky.
- error, output, 1, any mismatch or timeout; sticky.
- timeout, output, 1, timeout was the cause of termination; sticky.
- err_count, output, 8, mismatching words received, saturates at 255.

Behaviour:
- Reset (async, active-high) values:
  - link_resetn=0, tx_tvalid=0, tx_tdata=0, tx_tuser=0, tx_tlast=0, rx_tready=0.
  - done=0, error=0, timeout=0, err_count=0.
  - State=RST_HOLD, all counters 0.
- Word i sequence, identical for tx and expected rx:
  - tdata = (SEED + i) mod 2^TDATA_WIDTH.
  - tuser = ~i mod 2^TUSER_WIDTH.
  - tlast = (i mod PKT_LEN == PKT_LEN-1) or (i == NUM_WORDS-1).
- FSM:
  - RST_HOLD: link_resetn=0; count RESET_CYCLES cycles, then link_resetn<=1 and go to WAIT_LINK.
  - WAIT_LINK: wait for linkready=1, then go to RUN. If TIMEOUT cycles elapse first: timeout<=1, error<=1, go to DONE.
  - RUN: transmitter and receiver operate concurrently. When rx_idx reaches NUM_WORDS, go to DONE.
  - DONE: done=1, tx_tvalid=0, rx_tready=0; stays until reset.
- Transmitter (RUN only):
  - tx_tvalid registered high with word tx_idx while tx_idx<NUM_WORDS.
  - Transfer occurs on tx_tvalid && tx_tready. On transfer, tx_idx++ and the next word is presented in the following cycle, with no bubble required.
  - tx_t* are held stable while tx_tvalid && !tx_tready.
  - After the last transfer, tx_tvalid<=0.
- Receiver (RUN only):
  - rx_tready=1 (subject to the optional feature).
  - On rx_tvalid && rx_tready, compare tdata, tuser and tlast against word rx_idx. Any field mismatch increments err_count (saturating) and sets error.
  - rx_idx increments on every accepted word.
- Progress timer:
  - Resets on every rx acceptance and on RUN entry.
  - Reaching TIMEOUT in RUN sets timeout and error, and goes to DONE.
- Boundary rules:
  - Words received in RUN while rx_idx==NUM_WORDS cannot occur, because the FSM leaves RUN immediately.
  - Words arriving in DONE are not accepted (rx_tready=0).
  - Simultaneous tx and rx transfers in one cycle are both honoured.
  - NUM_WORDS=1 gives tlast=1 on the only word.
  - linkready dropping during RUN is not an error by itself; only the timeout catches a stall.
  - Reset asserted mid-run returns everything to reset values immediately and restarts the sequence from RST_HOLD.
- Pass condition: done=1 && error=0.

Optional Feature:
- Macro: PONYLINK_TGEN_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reset to seed) advances every cycle. In RUN, rx_tready = lfsr[0] | lfsr[1] (about 75% duty), which exercises master out-stream backpressure. The progress timer still counts only accepted words.
- Undefined: rx_tready=1 throughout RUN; no LFSR logic is present.

Test Plan:
- Default params, ideal loopback model echoing tx to rx after 10 cycles -> link_resetn rises 4 cycles after reset release; 16 words sent (first tdata 8'h17, tuser 4'hF; last tdata 8'h26, tuser 4'h0); tlast on words 3, 7, 11, 15; done=1, error=0, err_count=0.
- Model corrupts tdata of word 5 (XOR 8'h01) -> done=1, error=1, err_count=1, timeout=0.
- linkready held 0 -> after 1024 cycles in WAIT_LINK: timeout=1, error=1, done=1; no tx_tvalid ever asserted.
- Model drops word 9 -> only 15 words received, so the timeout fires 1024 cycles after the last acceptance; error=1, timeout=1. Words 9-14 are received shifted against the expected sequence (model sends 10..15 where 9..14 are expected), so err_count>=6.
- tx_tready toggled every other cycle plus a reset pulse mid-RUN at word 7 -> tx_t* stable while stalled; after reset all outputs return to reset values; the rerun passes with err_count=0.
- With PONYLINK_TGEN_BACKPRESSURE_EN, rerun of scenario 1 -> rx_tready observed low in some RUN cycles; still done=1, error=0.
